// File: rtl/jk_register_bank_if.sv
// Purpose : control/data bundle of the JK register bank (mode, J/K, count dir, serial in; Q, Qn, ser_out, tc).
// Latency : pure wiring, no state.
// Backpressure: none; the bank samples every enabled clock edge.
// Ports   : master = driver of en/mode/J/K/dir/ser_in, slave = the bank producing Q/Qn/ser_out/tc.
interface jk_register_bank_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] J;
   logic [WIDTH-1:0] K;
   logic             dir;
   logic             ser_in;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Qn;
   logic             ser_out;
   logic             tc;

   modport master (
      output en, mode, J, K, dir, ser_in,
      input  Q, Qn, ser_out, tc
   );

   modport slave (
      input  en, mode, J, K, dir, ser_in,
      output Q, Qn, ser_out, tc
   );
endinterface

// File: rtl/jk_register_bank.sv
// Purpose : WIDTH-bit JK flip-flop bank with JK / up-down count / shift / parallel-load modes.
// Latency : 1 clk for Q; Qn, ser_out and tc are combinational from Q (tc also from mode, dir).
// Backpressure: none; en=0 holds all state.
// Ports   : clk, rst_n (async active-low, loads RESET_VAL), bus (slave side of jk_register_bank_if).
module jk_register_bank #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               WRAP      = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   jk_register_bank_if.slave  bus
);

   localparam logic [1:0] MODE_JK    = 2'b00;
   localparam logic [1:0] MODE_COUNT = 2'b01;
   localparam logic [1:0] MODE_SHIFT = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] cnt_jk;
   logic             at_limit;

   // Ripple carry of the synchronous toggle chain. Bit i toggles when every
   // lower bit is 1 (up) or 0 (down). Carry out of the MSB means Q sits at the
   // limit for the current direction, which drives both tc and saturation.
   always_comb begin
      carry    = '0;
      carry[0] = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         carry[i+1] = carry[i] & (bus.dir ? q_r[i] : ~q_r[i]);
      end
      cnt_jk   = carry[WIDTH-1:0];
      at_limit = carry[WIDTH];
   end

   always_comb begin
      q_nxt = q_r;
      case (bus.mode)
         MODE_JK:    q_nxt = (bus.J & ~q_r) | (~bus.K & q_r);
         // Counter cells run with J=K=carry-in, i.e. toggle on carry.
         MODE_COUNT: begin
            if (!WRAP && at_limit) q_nxt = q_r;
            else                   q_nxt = (cnt_jk & ~q_r) | (~cnt_jk & q_r);
         end
         MODE_SHIFT: q_nxt = {q_r[WIDTH-2:0], bus.ser_in};
         MODE_LOAD:  q_nxt = bus.J;
         default:    q_nxt = q_r;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      q_r <= RESET_VAL;
      else if (bus.en) q_r <= q_nxt;
   end

   // Qn is derived from the single state register so it can never disagree with Q.
   assign bus.Q       = q_r;
   assign bus.Qn      = ~q_r;
   assign bus.ser_out = q_r[WIDTH-1];
   assign bus.tc      = (bus.mode == MODE_COUNT) && at_limit;

endmodule
